shwr_integral_capture: RTL and testbench
========================================

SHWR_INTEGRAL_CAPTURE -- requirements
Module: shwr_integral_capture

Interface
REQ-001 SHALL have port CLK120 input 1: 120 MHz clock; all logic on its rising edge.
REQ-002 SHALL have port RESET input 1: reset, synchronous, active-high.
REQ-003 SHALL have port TRIGGERED input 1: shower trigger window, same signal the integrator sees.
REQ-004 SHALL have port INTEGRAL input `SHWR_AREA_WIDTH: integrator running area.
REQ-005 SHALL have port PEAK input `ADC_WIDTH: integrator baseline-corrected peak.
REQ-006 SHALL have port BASELINE input `ADC_WIDTH+`SHWR_BASELINE_EXTRA_BITS: integrator pre-trigger baseline.
REQ-007 SHALL have port SATURATED input 1: integrator saturation flag.
REQ-008 SHALL have port ENABLE input 1: capture enable; low means no new captures start.
REQ-009 SHALL have ports OUT_INTEGRAL, OUT_PEAK and OUT_BASELINE as outputs, widths as inputs: FIFO head fields.
REQ-010 SHALL have port OUT_FLAGS output 3: {OVERFLOW, TRUNCATED, SATURATED} of head entry.
REQ-011 SHALL have port OUT_TAG output 8: event tag of head entry.
REQ-012 SHALL have port OUT_TSTAMP output 24: trigger timestamp of head entry.
REQ-013 SHALL have ports OUT_VALID output 1 and OUT_READY input 1: valid/ready read handshake.
REQ-014 SHALL have port FIFO_COUNT output 3: entries held, 0..4.

Function
REQ-015 FSM states SHALL be IDLE, WINDOW and WRITE.
REQ-016 IDLE->WINDOW SHALL occur on a TRIGGERED 0->1 edge with ENABLE=1; BASELINE SHALL be latched and the window counter cleared on that edge.
REQ-017 In WINDOW the counter SHALL increment each cycle; at count == `SHWR_AREA_BINS+2, INTEGRAL, PEAK and SATURATED SHALL be latched with TRUNCATED=0, then WRITE.
REQ-018 If TRIGGERED reads 0 in WINDOW before that count, inputs SHALL be latched on that same edge (pre-clear values) with TRUNCATED=1, then WRITE.
REQ-019 WRITE SHALL last one cycle: push entry if FIFO not full, tag++ (mod 256), go IDLE.
REQ-020 IDLE SHALL not re-arm until TRIGGERED has been seen low; a trigger still high after WRITE SHALL not start a capture.
REQ-021 FIFO SHALL be 4 entries, first-word-fall-through; OUT_VALID=1 iff FIFO_COUNT>0; pop on OUT_VALID&OUT_READY.
REQ-022 Simultaneous push and pop SHALL keep FIFO_COUNT unchanged, including when full.
REQ-023 Push when full without pop SHALL drop the entry and set sticky overflow; tag SHALL still increment.
REQ-024 The next accepted entry SHALL carry OVERFLOW=1 and the sticky bit SHALL clear on that push.
REQ-025 ENABLE falling mid-WINDOW SHALL not abort the capture in progress.
REQ-026 Pop when empty SHALL be ignored; head outputs SHALL hold their last value when empty.

Reset
REQ-027 RESET SHALL force IDLE, counter 0, tag 0, sticky overflow 0 and FIFO empty.
REQ-028 During RESET, OUT_VALID, FIFO_COUNT, OUT_FLAGS, OUT_TAG, OUT_TSTAMP, OUT_INTEGRAL, OUT_PEAK and OUT_BASELINE SHALL be 0.
REQ-029 RESET mid-WINDOW SHALL discard the capture; no entry SHALL be pushed.

Configuration
REQ-030 With SHWR_CAPTURE_TSTAMP_EN defined, a free-running 24-bit CLK120 counter (reset 0, wraps) SHALL be latched at the trigger edge into OUT_TSTAMP.
REQ-031 Without SHWR_CAPTURE_TSTAMP_EN, the timestamp counter and its storage SHALL be absent and OUT_TSTAMP SHALL be constant 0.

Verification
REQ-032 Bench: BASELINE=1000, trigger held 300 cycles, INTEGRAL=5000 and PEAK=800 at capture count -> one entry 5000/800/1000, FLAGS=000, TAG=0.
REQ-033 Bench: trigger lasts 10 cycles, INTEGRAL=120 then cleared on fall -> entry INTEGRAL=120, TRUNCATED=1.
REQ-034 Bench: OUT_READY=0, 6 triggers -> FIFO_COUNT=4, tags 0..3 held; after draining, next trigger entry has TAG=6, OVERFLOW=1; following entry OVERFLOW=0.
REQ-035 Bench: FIFO full, OUT_READY=1 during WRITE -> FIFO_COUNT stays 4, no overflow.
REQ-036 Bench: RESET at WINDOW count 50 -> FIFO_COUNT=0, OUT_VALID=0; trigger held high across reset release is not captured.
REQ-037 Bench (TSTAMP_EN): trigger edge at counter 0xFFFFFE, second at 0x000010 -> OUT_TSTAMP 0xFFFFFE then 0x000010.

Source files
------------

// File: rtl/shwr_integral_capture.sv
//==============================================================================
// Module   : shwr_integral_capture
// Brief    : Latches integrator results once per shower trigger into a 4-entry
//            first-word-fall-through FIFO with tag and overflow flags.
//            Optional macro SHWR_CAPTURE_TSTAMP_EN adds 24-bit trigger timestamps.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif
`ifndef SHWR_AREA_WIDTH
`define SHWR_AREA_WIDTH 19
`endif
`ifndef SHWR_BASELINE_EXTRA_BITS
`define SHWR_BASELINE_EXTRA_BITS 2
`endif
`ifndef SHWR_AREA_BINS
`define SHWR_AREA_BINS 256
`endif

module shwr_integral_capture (
   input  logic                                           CLK120,
   input  logic                                           RESET,
   input  logic                                           TRIGGERED,
   input  logic [`SHWR_AREA_WIDTH-1:0]                    INTEGRAL,
   input  logic [`ADC_WIDTH-1:0]                          PEAK,
   input  logic [`ADC_WIDTH+`SHWR_BASELINE_EXTRA_BITS-1:0] BASELINE,
   input  logic                                           SATURATED,
   input  logic                                           ENABLE,
   output logic [`SHWR_AREA_WIDTH-1:0]                    OUT_INTEGRAL,
   output logic [`ADC_WIDTH-1:0]                          OUT_PEAK,
   output logic [`ADC_WIDTH+`SHWR_BASELINE_EXTRA_BITS-1:0] OUT_BASELINE,
   output logic [2:0]                                     OUT_FLAGS,
   output logic [7:0]                                     OUT_TAG,
   output logic [23:0]                                    OUT_TSTAMP,
   output logic                                           OUT_VALID,
   input  logic                                           OUT_READY,
   output logic [2:0]                                     FIFO_COUNT
);
   localparam int c_AREA_W = `SHWR_AREA_WIDTH;
   localparam int c_ADC_W  = `ADC_WIDTH;
   localparam int c_BL_W   = `ADC_WIDTH + `SHWR_BASELINE_EXTRA_BITS;
   localparam int c_CNT_W  = $clog2(`SHWR_AREA_BINS + 3);
   localparam logic [c_CNT_W-1:0] c_CAP_CNT = c_CNT_W'(`SHWR_AREA_BINS + 2);
   localparam logic [2:0] c_DEPTH = 3'd4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WINDOW = 2'd1,
      WRITE  = 2'd2
   } state_t;

   state_t r_state, w_next_state;
   logic w_start, w_capture, w_trunc, w_write, w_push, w_pop;

   logic                r_trig_d;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [7:0]          r_tag;
   logic                r_ovf_sticky;
   logic [c_AREA_W-1:0] r_lat_int;
   logic [c_ADC_W-1:0]  r_lat_peak;
   logic [c_BL_W-1:0]   r_lat_bl;
   logic                r_lat_sat;
   logic                r_lat_trunc;

   logic [c_AREA_W-1:0] r_mem_int   [4];
   logic [c_ADC_W-1:0]  r_mem_peak  [4];
   logic [c_BL_W-1:0]   r_mem_bl    [4];
   logic [2:0]          r_mem_flags [4];
   logic [7:0]          r_mem_tag   [4];
   logic [1:0]          r_wr_ptr, r_rd_ptr, w_head;
   logic [2:0]          r_count;

   always_ff @(posedge CLK120) begin
      if (RESET) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_capture    = 1'b0;
      w_trunc      = 1'b0;
      w_write      = 1'b0;
      case (r_state)
         IDLE: begin
            if (TRIGGERED && !r_trig_d && ENABLE) begin
               w_start      = 1'b1;
               w_next_state = WINDOW;
            end
         end
         WINDOW: begin
            if (r_cnt == c_CAP_CNT) begin
               w_capture    = 1'b1;
               w_next_state = WRITE;
            end else if (!TRIGGERED) begin
               w_capture    = 1'b1;
               w_trunc      = 1'b1;
               w_next_state = WRITE;
            end
         end
         WRITE: begin
            w_write      = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // r_trig_d resets high so a trigger held across reset release is not an edge
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         r_trig_d     <= 1'b1;
         r_cnt        <= '0;
         r_tag        <= '0;
         r_ovf_sticky <= 1'b0;
         r_lat_int    <= '0;
         r_lat_peak   <= '0;
         r_lat_bl     <= '0;
         r_lat_sat    <= 1'b0;
         r_lat_trunc  <= 1'b0;
      end else begin
         r_trig_d <= TRIGGERED;
         if (w_start) begin
            r_cnt    <= '0;
            r_lat_bl <= BASELINE;
         end else if (r_state == WINDOW) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_capture) begin
            r_lat_int   <= INTEGRAL;
            r_lat_peak  <= PEAK;
            r_lat_sat   <= SATURATED;
            r_lat_trunc <= w_trunc;
         end
         if (w_write) begin
            r_tag        <= r_tag + 8'd1;
            r_ovf_sticky <= !w_push;
         end
      end
   end

   assign w_pop  = (r_count != 3'd0) && OUT_READY;
   assign w_push = w_write && ((r_count != c_DEPTH) || w_pop);

   always_ff @(posedge CLK120) begin
      if (RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < 4; i++) begin
            r_mem_int[i]   <= '0;
            r_mem_peak[i]  <= '0;
            r_mem_bl[i]    <= '0;
            r_mem_flags[i] <= '0;
            r_mem_tag[i]   <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem_int[r_wr_ptr]   <= r_lat_int;
            r_mem_peak[r_wr_ptr]  <= r_lat_peak;
            r_mem_bl[r_wr_ptr]    <= r_lat_bl;
            r_mem_flags[r_wr_ptr] <= {r_ovf_sticky, r_lat_trunc, r_lat_sat};
            r_mem_tag[r_wr_ptr]   <= r_tag;
            r_wr_ptr              <= r_wr_ptr + 2'd1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
         if (w_push && !w_pop)      r_count <= r_count + 3'd1;
         else if (w_pop && !w_push) r_count <= r_count - 3'd1;
      end
   end

   // When empty, show the last popped slot so head outputs hold their value
   assign w_head       = (r_count == 3'd0) ? (r_rd_ptr - 2'd1) : r_rd_ptr;
   assign OUT_INTEGRAL = r_mem_int[w_head];
   assign OUT_PEAK     = r_mem_peak[w_head];
   assign OUT_BASELINE = r_mem_bl[w_head];
   assign OUT_FLAGS    = r_mem_flags[w_head];
   assign OUT_TAG      = r_mem_tag[w_head];
   assign OUT_VALID    = (r_count != 3'd0);
   assign FIFO_COUNT   = r_count;

`ifdef SHWR_CAPTURE_TSTAMP_EN
   logic [23:0] r_ts_cnt, r_ts_lat;
   logic [23:0] r_mem_ts [4];

   always_ff @(posedge CLK120) begin
      if (RESET) begin
         r_ts_cnt <= '0;
         r_ts_lat <= '0;
         for (int i = 0; i < 4; i++) r_mem_ts[i] <= '0;
      end else begin
         r_ts_cnt <= r_ts_cnt + 24'd1;
         if (w_start) r_ts_lat <= r_ts_cnt;
         if (w_push)  r_mem_ts[r_wr_ptr] <= r_ts_lat;
      end
   end

   assign OUT_TSTAMP = r_mem_ts[w_head];
`else
   assign OUT_TSTAMP = 24'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shwr_integral_capture.sv
//==============================================================================
// Module   : tb_shwr_integral_capture
// Brief    : Randomized self-checking bench with an event-level queue model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif
`ifndef SHWR_AREA_WIDTH
`define SHWR_AREA_WIDTH 19
`endif
`ifndef SHWR_BASELINE_EXTRA_BITS
`define SHWR_BASELINE_EXTRA_BITS 2
`endif
`ifndef SHWR_AREA_BINS
`define SHWR_AREA_BINS 256
`endif

module tb_shwr_integral_capture;
   localparam int AW  = `SHWR_AREA_WIDTH;
   localparam int ADW = `ADC_WIDTH;
   localparam int BW  = `ADC_WIDTH + `SHWR_BASELINE_EXTRA_BITS;
   localparam int c_X = `SHWR_AREA_BINS + 2;

   typedef struct packed {
      logic [AW-1:0]  integral;
      logic [ADW-1:0] peak;
      logic [BW-1:0]  baseline;
      logic [2:0]     flags;
      logic [7:0]     tag;
      logic [23:0]    ts;
   } entry_t;

   logic           CLK120 = 1'b0, RESET = 1'b1, TRIGGERED = 1'b0;
   logic           SATURATED = 1'b0, ENABLE = 1'b1, OUT_READY = 1'b0;
   logic [AW-1:0]  INTEGRAL = '0;
   logic [ADW-1:0] PEAK = '0;
   logic [BW-1:0]  BASELINE = '0;
   logic [AW-1:0]  OUT_INTEGRAL;
   logic [ADW-1:0] OUT_PEAK;
   logic [BW-1:0]  OUT_BASELINE;
   logic [2:0]     OUT_FLAGS, FIFO_COUNT;
   logic [7:0]     OUT_TAG;
   logic [23:0]    OUT_TSTAMP;
   logic           OUT_VALID;

   entry_t         mq[$];
   logic [7:0]     m_tag = '0;
   logic           m_ovf = 1'b0;
   logic [23:0]    m_ts = '0;
   logic [AW-1:0]  stim_int  [512];
   logic [ADW-1:0] stim_peak [512];
   logic           stim_sat  [512];
   bit             rand_ready = 1'b0, ready_at_write = 1'b0;
   int             n_checks = 0, n_fail = 0;

   shwr_integral_capture dut (
      .CLK120(CLK120), .RESET(RESET), .TRIGGERED(TRIGGERED), .INTEGRAL(INTEGRAL),
      .PEAK(PEAK), .BASELINE(BASELINE), .SATURATED(SATURATED), .ENABLE(ENABLE),
      .OUT_INTEGRAL(OUT_INTEGRAL), .OUT_PEAK(OUT_PEAK), .OUT_BASELINE(OUT_BASELINE),
      .OUT_FLAGS(OUT_FLAGS), .OUT_TAG(OUT_TAG), .OUT_TSTAMP(OUT_TSTAMP),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .FIFO_COUNT(FIFO_COUNT)
   );

   always #4 CLK120 = ~CLK120;

   // One clock: model pops whatever the reader takes, then any capture lands
   task automatic tick(input bit do_push, input entry_t e);
      @(posedge CLK120);
      if (RESET) begin
         mq.delete(); m_tag = '0; m_ovf = 1'b0; m_ts = '0;
      end else begin
         if (OUT_READY && mq.size() > 0) mq.delete(0);
         if (do_push) begin
            e.tag = m_tag;
            if (mq.size() < 4) begin
               e.flags[2] = m_ovf; m_ovf = 1'b0; mq.push_back(e);
            end else m_ovf = 1'b1;
            m_tag = m_tag + 8'd1;
         end
         m_ts = m_ts + 24'd1;
      end
      @(negedge CLK120);
   endtask

   task automatic fill_random();
      for (int k = 0; k < 512; k++) begin
         stim_int[k] = AW'($urandom); stim_peak[k] = ADW'($urandom); stim_sat[k] = 1'($urandom);
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1; TRIGGERED = 1'b0; OUT_READY = 1'b0;
      tick(1'b0, '0); tick(1'b0, '0);
      RESET = 1'b0;
      tick(1'b0, '0); tick(1'b0, '0);
   endtask

   // Trigger high for L cycles; capture at cycle min(L, X+1), written one later
   task automatic drive_event(input int L, input logic [BW-1:0] bl, input int en_off, input int gap);
      int kcap, klast;
      entry_t e;
      kcap  = (L >= c_X + 1) ? c_X + 1 : L;
      klast = ((L > kcap + 2) ? L : kcap + 2) + gap;
      e = '0;
      e.integral = stim_int[kcap];
      e.peak     = stim_peak[kcap];
      e.baseline = bl;
      e.flags    = {1'b0, (L < c_X + 1), stim_sat[kcap]};
`ifdef SHWR_CAPTURE_TSTAMP_EN
      e.ts = m_ts;
`endif
      for (int k = 0; k < klast; k++) begin
         TRIGGERED = (k < L);
         ENABLE    = (k < en_off);
         INTEGRAL  = stim_int[k];
         PEAK      = stim_peak[k];
         SATURATED = stim_sat[k];
         BASELINE  = (k == 0) ? bl : BW'($urandom);
         if (rand_ready)          OUT_READY = 1'($urandom);
         else if (ready_at_write) OUT_READY = (k == kcap + 1);
         tick((en_off > 0) && (k == kcap + 1), e);
      end
      ENABLE = 1'b1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      tick(1'b0, '0); tick(1'b0, '0);
      n_checks++;
      if ({OUT_VALID, FIFO_COUNT, OUT_FLAGS, OUT_TAG} !== '0) begin
         n_fail++; $display("FAIL reset_ctrl: got valid=%0b count=%0d flags=%b tag=%0d want all 0", OUT_VALID, FIFO_COUNT, OUT_FLAGS, OUT_TAG);
      end
      n_checks++;
      if ({OUT_INTEGRAL, OUT_PEAK, OUT_BASELINE, OUT_TSTAMP} !== '0) begin
         n_fail++; $display("FAIL reset_data: got int=%0d peak=%0d bl=%0d ts=%h want all 0", OUT_INTEGRAL, OUT_PEAK, OUT_BASELINE, OUT_TSTAMP);
      end
      RESET = 1'b0;
      tick(1'b0, '0); tick(1'b0, '0);
   endtask

   task automatic test_full_capture();
      for (int k = 0; k < 512; k++) begin stim_int[k] = 5000; stim_peak[k] = 800; stim_sat[k] = 1'b0; end
      drive_event(300, BW'(1000), 1000, 4);
      n_checks++;
      if (FIFO_COUNT !== 3'd1 || OUT_VALID !== 1'b1) begin
         n_fail++; $display("FAIL full_count: got count=%0d valid=%0b want 1/1", FIFO_COUNT, OUT_VALID);
      end
      n_checks++;
      if (OUT_INTEGRAL !== AW'(5000) || OUT_PEAK !== ADW'(800) || OUT_BASELINE !== BW'(1000)) begin
         n_fail++; $display("FAIL full_data: got %0d/%0d/%0d want 5000/800/1000", OUT_INTEGRAL, OUT_PEAK, OUT_BASELINE);
      end
      n_checks++;
      if (OUT_FLAGS !== 3'b000 || OUT_TAG !== 8'd0 || OUT_TSTAMP !== mq[0].ts) begin
         n_fail++; $display("FAIL full_meta: got flags=%b tag=%0d ts=%h want 000/0/%h", OUT_FLAGS, OUT_TAG, OUT_TSTAMP, mq[0].ts);
      end
      OUT_READY = 1'b1; tick(1'b0, '0);
      tick(1'b0, '0);
      OUT_READY = 1'b0;
      n_checks++;
      if (FIFO_COUNT !== 3'd0 || OUT_VALID !== 1'b0 || OUT_INTEGRAL !== AW'(5000)) begin
         n_fail++; $display("FAIL empty_hold: got count=%0d valid=%0b int=%0d want 0/0/5000", FIFO_COUNT, OUT_VALID, OUT_INTEGRAL);
      end
   endtask

   task automatic test_truncated();
      fill_random();
      for (int k = 0; k < 512; k++) stim_int[k] = (k <= 10) ? AW'(120) : AW'(0);
      drive_event(10, BW'($urandom), 1000, 4);
      n_checks++;
      if (OUT_INTEGRAL !== AW'(120) || OUT_FLAGS[1] !== 1'b1) begin
         n_fail++; $display("FAIL trunc: got int=%0d flags=%b want 120/x1x", OUT_INTEGRAL, OUT_FLAGS);
      end
      n_checks++;
      if ({OUT_INTEGRAL, OUT_PEAK, OUT_BASELINE, OUT_FLAGS, OUT_TAG, OUT_TSTAMP} !== mq[0]) begin
         n_fail++; $display("FAIL trunc_entry: got tag=%0d peak=%0d bl=%0d want tag=%0d peak=%0d bl=%0d", OUT_TAG, OUT_PEAK, OUT_BASELINE, mq[0].tag, mq[0].peak, mq[0].baseline);
      end
      OUT_READY = 1'b1; tick(1'b0, '0); OUT_READY = 1'b0;
   endtask

   task automatic test_enable();
      fill_random();
      drive_event(40, BW'($urandom), 0, 4);
      n_checks++;
      if (FIFO_COUNT !== 3'd0) begin
         n_fail++; $display("FAIL enable_low: got count=%0d want 0", FIFO_COUNT);
      end
      drive_event(40, BW'($urandom), 5, 4);
      n_checks++;
      if (FIFO_COUNT !== 3'd1 || {OUT_INTEGRAL, OUT_PEAK, OUT_BASELINE, OUT_FLAGS, OUT_TAG, OUT_TSTAMP} !== mq[0]) begin
         n_fail++; $display("FAIL enable_drop: got count=%0d tag=%0d int=%0d want 1/%0d/%0d", FIFO_COUNT, OUT_TAG, OUT_INTEGRAL, mq[0].tag, mq[0].integral);
      end
      OUT_READY = 1'b1; tick(1'b0, '0); OUT_READY = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int n = 0; n < 6; n++) begin
         fill_random(); drive_event($urandom_range(3, 40), BW'($urandom), 1000, 3);
      end
      n_checks++;
      if (FIFO_COUNT !== 3'd4) begin
         n_fail++; $display("FAIL ovf_count: got %0d want 4", FIFO_COUNT);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (OUT_TAG !== 8'(i) || {OUT_INTEGRAL, OUT_PEAK, OUT_BASELINE, OUT_FLAGS, OUT_TAG, OUT_TSTAMP} !== mq[0]) begin
            n_fail++; $display("FAIL ovf_drain%0d: got tag=%0d int=%0d want tag=%0d int=%0d", i, OUT_TAG, OUT_INTEGRAL, i, mq[0].integral);
         end
         OUT_READY = 1'b1; tick(1'b0, '0); OUT_READY = 1'b0;
      end
      fill_random(); drive_event(20, BW'($urandom), 1000, 3);
      n_checks++;
      if (OUT_TAG !== 8'd6 || OUT_FLAGS[2] !== 1'b1) begin
         n_fail++; $display("FAIL ovf_flag: got tag=%0d flags=%b want 6/1xx", OUT_TAG, OUT_FLAGS);
      end
      OUT_READY = 1'b1; tick(1'b0, '0); OUT_READY = 1'b0;
      fill_random(); drive_event(20, BW'($urandom), 1000, 3);
      n_checks++;
      if (OUT_TAG !== 8'd7 || OUT_FLAGS[2] !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear: got tag=%0d flags=%b want 7/0xx", OUT_TAG, OUT_FLAGS);
      end
      OUT_READY = 1'b1; tick(1'b0, '0); OUT_READY = 1'b0;
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int n = 0; n < 4; n++) begin
         fill_random(); drive_event($urandom_range(3, 30), BW'($urandom), 1000, 3);
      end
      ready_at_write = 1'b1;
      fill_random(); drive_event(25, BW'($urandom), 1000, 3);
      ready_at_write = 1'b0; OUT_READY = 1'b0;
      n_checks++;
      if (FIFO_COUNT !== 3'd4 || OUT_TAG !== 8'd1) begin
         n_fail++; $display("FAIL fullpp_count: got count=%0d tag=%0d want 4/1", FIFO_COUNT, OUT_TAG);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (OUT_FLAGS[2] !== 1'b0 || {OUT_INTEGRAL, OUT_PEAK, OUT_BASELINE, OUT_FLAGS, OUT_TAG, OUT_TSTAMP} !== mq[0]) begin
            n_fail++; $display("FAIL fullpp_drain%0d: got tag=%0d flags=%b want tag=%0d flags=%b", i, OUT_TAG, OUT_FLAGS, mq[0].tag, mq[0].flags);
         end
         OUT_READY = 1'b1; tick(1'b0, '0); OUT_READY = 1'b0;
      end
   endtask

   task automatic test_random();
      int L, en_off;
      entry_t got;
      do_reset();
      rand_ready = 1'b1;
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 7))
            0:       L = $urandom_range(1, 2);
            1:       L = c_X - 1 + $urandom_range(0, 3);
            2, 3:    L = $urandom_range(3, 300);
            default: L = $urandom_range(3, 60);
         endcase
         case ($urandom_range(0, 9))
            0:       en_off = 0;
            1:       en_off = $urandom_range(1, 8);
            default: en_off = 1000;
         endcase
         fill_random();
         drive_event(L, BW'($urandom), en_off, $urandom_range(2, 6));
         got = {OUT_INTEGRAL, OUT_PEAK, OUT_BASELINE, OUT_FLAGS, OUT_TAG, OUT_TSTAMP};
         n_checks++;
         if (FIFO_COUNT !== 3'(mq.size()) || OUT_VALID !== (mq.size() > 0)) begin
            n_fail++; $display("FAIL rand_count%0d: got count=%0d valid=%0b want %0d", n, FIFO_COUNT, OUT_VALID, mq.size());
         end
         if (mq.size() > 0) begin
            n_checks++;
            if (got !== mq[0]) begin
               n_fail++; $display("FAIL rand_head%0d: got %h want %h (L=%0d)", n, got, mq[0], L);
            end
         end
      end
      rand_ready = 1'b0; OUT_READY = 1'b1;
      for (int i = 0; i < 6; i++) tick(1'b0, '0);
      OUT_READY = 1'b0;
   endtask

   task automatic test_reset_mid();
      fill_random();
      TRIGGERED = 1'b1;
      for (int k = 0; k < 51; k++) tick(1'b0, '0);
      RESET = 1'b1; tick(1'b0, '0);
      n_checks++;
      if (FIFO_COUNT !== 3'd0 || OUT_VALID !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_now: got count=%0d valid=%0b want 0/0", FIFO_COUNT, OUT_VALID);
      end
      RESET = 1'b0;
      for (int k = 0; k < 20; k++) tick(1'b0, '0);
      TRIGGERED = 1'b0;
      for (int k = 0; k < c_X + 10; k++) tick(1'b0, '0);
      n_checks++;
      if (FIFO_COUNT !== 3'd0 || OUT_VALID !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_held: got count=%0d valid=%0b want 0/0", FIFO_COUNT, OUT_VALID);
      end
      drive_event(30, BW'($urandom), 1000, 3);
      n_checks++;
      if (FIFO_COUNT !== 3'd1 || OUT_TAG !== 8'd0) begin
         n_fail++; $display("FAIL rstmid_after: got count=%0d tag=%0d want 1/0", FIFO_COUNT, OUT_TAG);
      end
      OUT_READY = 1'b1; tick(1'b0, '0); OUT_READY = 1'b0;
   endtask

`ifdef SHWR_CAPTURE_TSTAMP_EN
   task automatic test_tstamp();
      do_reset();
      fill_random();
      force dut.r_ts_cnt = 24'hFFFFFE; #1; release dut.r_ts_cnt; m_ts = 24'hFFFFFE;
      drive_event(20, BW'($urandom), 1000, 3);
      force dut.r_ts_cnt = 24'h000010; #1; release dut.r_ts_cnt; m_ts = 24'h000010;
      drive_event(20, BW'($urandom), 1000, 3);
      n_checks++;
      if (OUT_TSTAMP !== 24'hFFFFFE) begin
         n_fail++; $display("FAIL tstamp_wrap: got %h want fffffe", OUT_TSTAMP);
      end
      OUT_READY = 1'b1; tick(1'b0, '0); OUT_READY = 1'b0;
      n_checks++;
      if (OUT_TSTAMP !== 24'h000010) begin
         n_fail++; $display("FAIL tstamp_second: got %h want 000010", OUT_TSTAMP);
      end
      OUT_READY = 1'b1; tick(1'b0, '0); OUT_READY = 1'b0;
   endtask
`endif

   initial begin
      @(negedge CLK120);
      test_reset();
      test_full_capture();
      test_truncated();
      test_enable();
      test_overflow();
      test_full_push_pop();
      test_random();
      test_reset_mid();
`ifdef SHWR_CAPTURE_TSTAMP_EN
      test_tstamp();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
